nibble_add_seq: RTL and testbench

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_seq_pkg.sv | 10 +
 rtl/nibble_add_seq_fa.sv | 10 +
 rtl/nibble_add_seq.sv | 94 +++++++++
 tb/tb_nibble_add_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/nibble_add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_add_seq_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_add_seq_fa.sv
// 4-bit adder slice with carry in/out; the only arithmetic on operand data.
module full_add_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_carry
);
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
endmodule

// File: rtl/nibble_add_seq.sv
// Nibble-serial adder: one 4-bit slice per clock through a shared adder,
// result held with a valid/ready handshake.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int W = NIBBLE_W * NIBBLES
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_sum,
  output logic         o_carry,
  output logic         o_busy
);
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            carry_q, cout_q;
  logic [CW-1:0]   cnt;
  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
  logic            slice_carry;

  assign slice_a = a_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];
  assign slice_b = b_q[int'(cnt)*NIBBLE_W +: NIBBLE_W];

  full_add_4bit u_fa (
    .i_a    (slice_a),
    .i_b    (slice_b),
    .i_cin  (carry_q),
    .o_sum  (slice_sum),
    .o_carry(slice_carry)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid)     state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (i_ready)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE) && !i_rst;
    o_valid = (state == DONE);
    o_busy  = (state == RUN) || (state == DONE);
  end

  // Datapath only moves in IDLE (load) and RUN (one slice per edge); DONE holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          a_q     <= i_a;
          b_q     <= i_b;
          carry_q <= i_cin;
          cnt     <= '0;
        end
        RUN: begin
          sum_q[int'(cnt)*NIBBLE_W +: NIBBLE_W] <= slice_sum;
          carry_q <= slice_carry;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) cout_q <= slice_carry;
        end
        default: ;
      endcase
    end
  end

  assign o_sum   = sum_q;
  assign o_carry = cout_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Randomized scoreboard bench for nibble_add_seq: driver pushes a+b+cin,
// monitor pops on each accepted result and checks latency and hold.
module tb_nibble_add_seq;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;
  typedef logic [W:0] res_t;
  typedef struct { res_t res; int acc; } exp_t;

  logic         i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_cin = 1'b0, i_ready = 1'b0;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic         o_ready, o_valid, o_carry, o_busy;
  logic [W-1:0] o_sum;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_cin  (i_cin),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sum  (o_sum),
    .o_carry(o_carry),
    .o_busy (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int   checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  bit   ready_rand = 1'b0, ready_fixed = 1'b1;
  logic prev_v = 1'b0;
  res_t held;

  always @(posedge i_clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge i_clk); #1;
    i_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  task automatic chk(input string name, input res_t act, input res_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: result popped when o_valid & i_ready will complete at the next edge
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: actual %h required none", {o_carry, o_sum});
        end else
          chk("latency", res_t'(cyc - sb[0].acc), res_t'(NIBBLES));
        held = {o_carry, o_sum};
      end else if (o_valid && prev_v)
        chk("hold", {o_carry, o_sum}, held);
      if (o_valid && i_ready && sb.size() > 0) begin
        chk("result", {o_carry, o_sum}, sb[0].res);
        sb.delete(0);
      end
    end
    prev_v = o_valid;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n = 0;
    @(posedge i_clk); #1;
    i_a = a; i_b = b; i_cin = c; i_valid = 1'b1;
    @(negedge i_clk);
    while (!o_ready && n < 200) begin @(negedge i_clk); n++; end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: o_ready %b required 1", o_ready);
      i_valid = 1'b0;
      return;
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    sb.push_back('{res: {1'b0, a} + {1'b0, b} + res_t'(c), acc: cyc});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge i_clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending %0d required 0", sb.size());
    end
  endtask

  initial begin
    res_t bp_exp;
    int   n;

    // Reset held for two edges
    @(posedge i_clk);
    @(negedge i_clk);
    chk("ready_in_reset", res_t'(o_ready), res_t'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_valid", res_t'(o_valid), res_t'(0));
    chk("rst_busy",  res_t'(o_busy),  res_t'(0));
    chk("rst_ready", res_t'(o_ready), res_t'(1));
    chk("rst_sum",   res_t'(o_sum),   res_t'(0));
    chk("rst_carry", res_t'(o_carry), res_t'(0));

    issue(16'h1234, 16'h4321, 1'b0); drain();
    issue(16'hFFFF, 16'h0000, 1'b1); drain();
    issue(16'h8000, 16'h8000, 1'b0); drain();

    // Backpressure with new requests offered while DONE
    ready_fixed = 1'b0;
    issue(16'h0F0F, 16'h0101, 1'b1);
    bp_exp = sb[0].res;
    n = 0;
    while (!o_valid && n < 50) begin @(negedge i_clk); n++; end
    chk("bp_reach_done", res_t'(o_valid), res_t'(1));
    repeat (5) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_a = W'($urandom); i_b = W'($urandom); i_cin = 1'b1;
      @(negedge i_clk);
      chk("bp_valid", res_t'(o_valid), res_t'(1));
      chk("bp_ready", res_t'(o_ready), res_t'(0));
      chk("bp_sum", {o_carry, o_sum}, bp_exp);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    ready_fixed = 1'b1;
    drain();
    repeat (6) @(negedge i_clk);
    chk("bp_no_accept", res_t'(o_busy), res_t'(0));

    // Reset two edges into an operation
    issue(16'hABCD, 16'h1111, 1'b0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    sb.delete(sb.size() - 1);
    @(negedge i_clk);
    chk("mid_rst_busy",  res_t'(o_busy),  res_t'(0));
    chk("mid_rst_ready", res_t'(o_ready), res_t'(1));
    chk("mid_rst_sum",   res_t'(o_sum),   res_t'(0));
    repeat (8) begin
      @(negedge i_clk);
      chk("mid_rst_no_valid", res_t'(o_valid), res_t'(0));
    end
    issue(16'h2468, 16'hFDB9, 1'b1); drain();

    // Random traffic with random consumer stalls
    ready_rand = 1'b1;
    for (int i = 0; i < 200; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    drain();
    ready_rand = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("final_idle", res_t'(o_busy), res_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
